// File: rtl/div_iterative.sv
// div_iterative
//   Radix-2 restoring integer divider for MIPS DIV/DIVU. A request is
//   accepted in IDLE. It then iterates for 32 cycles in BUSY. The signed
//   result is presented in DONE for a single cycle. flush aborts an
//   operation at any point without disturbing the last result.
//
// Ports
//   clk         rising-edge clock
//   resetn      synchronous active-low reset
//   flush       abort any in-flight divide (wins over div_start)
//   div_start   request level, held by the ALU until div_done
//   div_signed  1 = DIV (two's complement), 0 = DIVU
//   dividend    rs operand, sampled when the request is accepted
//   divisor     rt operand, sampled when the request is accepted
//   div_busy    accepted operation not yet complete (includes request cycle)
//   div_done    one-cycle completion pulse
//   whilo_data  {remainder, quotient} = {HI, LO}, holds the last result
module div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               div_busy,
    output logic               div_done,
    output logic [2*WIDTH-1:0] whilo_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] whilo_q, whilo_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic               fits;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    // Two's complement negate when neg is set; wraps mod 2^WIDTH, so the
    // magnitude of 0x8000_0000 stays 0x8000_0000 (correct when unsigned).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // One restoring step. The shifted partial remainder can reach 33 bits,
    // so the trial subtraction carries an extra guard bit for the sign.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs_q};
        fits     = ~trial[WIDTH+1];
        rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
        // With a zero divisor every trial fits, so the remainder ends up as
        // |dividend|. Re-applying the dividend sign restores the original
        // dividend. Only the quotient needs forcing.
        rem_fix  = cond_neg(rem_step, r_neg_q);
        quo_fix  = dz_q ? '1 : cond_neg(quo_step, q_neg_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        whilo_d = whilo_q;

        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    state_d = S_BUSY;
                    cnt_d   = 5'd0;
                    rem_d   = '0;
                    quo_d   = cond_neg(dividend, div_signed & dividend[WIDTH-1]);
                    dvs_d   = cond_neg(divisor, div_signed & divisor[WIDTH-1]);
                    q_neg_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = div_signed & dividend[WIDTH-1];
                    dz_d    = (divisor == '0);
                end
            end
            S_BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    whilo_d = {rem_fix, quo_fix};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: return to IDLE and keep the previously published result.
        if (flush) begin
            state_d = S_IDLE;
            whilo_d = whilo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            whilo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            whilo_q <= whilo_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
        dz_q    <= dz_d;
    end

    assign div_busy   = (state_q == S_BUSY) |
                        ((state_q == S_IDLE) & div_start & ~flush);
    assign div_done   = (state_q == S_DONE);
    assign whilo_data = whilo_q;

endmodule
